// File: rtl/spi_bus_arbiter.sv
// Two-master SPI bus arbiter: round-robin ownership of one shared bus, IDLE_GAP idle cycles between owners.
// Define SPI_ARB_TIMEOUT_EN to revoke ownerships after TIMEOUT_CYCLES and mask the offender until it releases req.
module spi_bus_arbiter #(
    parameter int unsigned IDLE_GAP       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst_in_n,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic       m0_sclk,
    input  logic       m0_mosi,
    input  logic [1:0] m0_ncs,
    output logic       m0_miso,
    input  logic       m1_sclk,
    input  logic       m1_mosi,
    input  logic [1:0] m1_ncs,
    output logic       m1_miso,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic [1:0] spi_ncs,
    input  logic       spi_miso,
    output logic       timeout
);

    typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1, S_GAP} state_t;

    localparam logic [3:0]  GAP_LOAD = 4'(IDLE_GAP - 1);
    localparam logic [15:0] CNT_SAT  = 16'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;
    logic [3:0]  gap_q, gap_d;
    logic [1:0]  eligible;
    logic        owner;
    logic        pick;
`ifdef SPI_ARB_TIMEOUT_EN
    logic        timeout_q, timeout_d;
    logic [1:0]  mask_q, mask_d;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        owner   = (state_q == S_OWN1);
        pick    = 1'b0;
        // The ownership counter saturates at the timeout limit rather than wrapping.
        cnt_inc = (cnt_q >= CNT_SAT) ? cnt_q : cnt_q + 16'd1;
`ifdef SPI_ARB_TIMEOUT_EN
        timeout_d = 1'b0;
        mask_d    = mask_q & req;
        eligible  = req & ~mask_q;
`else
        eligible  = req;
`endif
        case (state_q)
            S_IDLE: begin
                if (eligible != 2'b00) begin
                    pick    = (eligible == 2'b11) ? ~last_q : eligible[1];
                    state_d = pick ? S_OWN1 : S_OWN0;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    last_d  = pick;
                    cnt_d   = '0;
                end
            end
            S_OWN0, S_OWN1: begin
                cnt_d = cnt_inc;
                if (!req[owner]) begin
                    state_d = S_GAP;
                    gnt_d   = 2'b00;
                    gap_d   = GAP_LOAD;
`ifdef SPI_ARB_TIMEOUT_EN
                end else if (cnt_inc >= CNT_SAT) begin
                    state_d       = S_GAP;
                    gnt_d         = 2'b00;
                    gap_d         = GAP_LOAD;
                    timeout_d     = 1'b1;
                    mask_d[owner] = 1'b1;
`endif
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) state_d = S_IDLE;
                else               gap_d   = gap_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_in_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= 2'b00;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            gap_q     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
            mask_q    <= 2'b00;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
`ifdef SPI_ARB_TIMEOUT_EN
            timeout_q <= timeout_d;
            mask_q    <= mask_d;
`endif
        end
    end

    // The bus mux selects on the registered grant itself, so grant and mux can never disagree.
    always_comb begin
        spi_sclk = 1'b0;
        spi_mosi = 1'b1;
        spi_ncs  = 2'b11;
        m0_miso  = 1'b1;
        m1_miso  = 1'b1;
        if (gnt_q[0]) begin
            spi_sclk = m0_sclk;
            spi_mosi = m0_mosi;
            spi_ncs  = m0_ncs;
            m0_miso  = spi_miso;
        end else if (gnt_q[1]) begin
            spi_sclk = m1_sclk;
            spi_mosi = m1_mosi;
            spi_ncs  = m1_ncs;
            m1_miso  = spi_miso;
        end
    end

    assign gnt = gnt_q;
`ifdef SPI_ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: directed vector table, hand-written corner sequences, then random traffic vs a reference model.
module tb_spi_bus_arbiter;

    localparam int IDLE_GAP = 2;
    localparam int TIMEOUT  = 16;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_in_n;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       m0_sclk, m0_mosi, m0_miso;
    logic [1:0] m0_ncs;
    logic       m1_sclk, m1_mosi, m1_miso;
    logic [1:0] m1_ncs;
    logic       spi_sclk, spi_mosi, spi_miso;
    logic [1:0] spi_ncs;
    logic       timeout;

    spi_bus_arbiter #(.IDLE_GAP(IDLE_GAP), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst_in_n(rst_in_n), .req(req), .gnt(gnt),
        .m0_sclk(m0_sclk), .m0_mosi(m0_mosi), .m0_ncs(m0_ncs), .m0_miso(m0_miso),
        .m1_sclk(m1_sclk), .m1_mosi(m1_mosi), .m1_ncs(m1_ncs), .m1_miso(m1_miso),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ncs(spi_ncs), .spi_miso(spi_miso),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: who owns the bus, how many idle cycles must still pass, round-robin memory, masks.
    int       mo_owner;
    int       mo_block;
    int       mo_len;
    int       mo_last;
    bit [1:0] mo_mask;
    bit       mo_to;

    task automatic model_step();
        bit [1:0] elig;
        if (!rst_in_n) begin
            mo_owner = -1; mo_block = 0; mo_len = 0; mo_last = 1; mo_mask = 2'b00; mo_to = 1'b0;
            return;
        end
        mo_to = 1'b0;
        if (TO_EN) mo_mask = mo_mask & req;
        if (mo_owner >= 0) begin
            mo_len++;
            if (!req[mo_owner]) begin
                mo_owner = -1;
                mo_block = IDLE_GAP;
            end else if (TO_EN && mo_len >= TIMEOUT) begin
                mo_mask[mo_owner] = 1'b1;
                mo_owner = -1;
                mo_block = IDLE_GAP;
                mo_to    = 1'b1;
            end
        end else if (mo_block > 0) begin
            mo_block--;
        end else begin
            elig = req & ~mo_mask;
            if (elig != 2'b00) begin
                if (elig == 2'b11) mo_owner = 1 - mo_last;
                else               mo_owner = elig[1] ? 1 : 0;
                mo_last = mo_owner;
                mo_len  = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Checks every bus-facing output against what the given owner (-1 = none) implies for the present pin values.
    task automatic chk_bus(input string tag, input int own);
        logic [1:0] gnt_e, ncs_e;
        logic       sclk_e, mosi_e, m0m_e, m1m_e;
        gnt_e = 2'b00; ncs_e = 2'b11; sclk_e = 1'b0; mosi_e = 1'b1; m0m_e = 1'b1; m1m_e = 1'b1;
        if (own == 0) begin
            gnt_e = 2'b01; ncs_e = m0_ncs; sclk_e = m0_sclk; mosi_e = m0_mosi; m0m_e = spi_miso;
        end else if (own == 1) begin
            gnt_e = 2'b10; ncs_e = m1_ncs; sclk_e = m1_sclk; mosi_e = m1_mosi; m1m_e = spi_miso;
        end
        chk({tag, ".gnt"},     16'(gnt),      16'(gnt_e));
        chk({tag, ".spi_ncs"}, 16'(spi_ncs),  16'(ncs_e));
        chk({tag, ".sclk"},    16'(spi_sclk), 16'(sclk_e));
        chk({tag, ".mosi"},    16'(spi_mosi), 16'(mosi_e));
        chk({tag, ".m0_miso"}, 16'(m0_miso),  16'(m0m_e));
        chk({tag, ".m1_miso"}, 16'(m1_miso),  16'(m1m_e));
    endtask

    typedef struct packed {
        logic       rst_n;
        logic [1:0] req;
        logic [1:0] gnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [1:0] q, input logic [1:0] g);
        vec_t v;
        v.rst_n = r; v.req = q; v.gnt = g;
        tbl.push_back(v);
    endtask

    initial begin
        rst_in_n = 1'b0; req = 2'b00;
        m0_sclk = 1'b1; m0_mosi = 1'b0; m0_ncs = 2'b10;
        m1_sclk = 1'b1; m1_mosi = 1'b0; m1_ncs = 2'b01;
        spi_miso = 1'b0;

        // Each row: inputs presented before an edge, grant required after it.
        add(0, 2'b00, 2'b00); add(0, 2'b00, 2'b00);
        add(1, 2'b01, 2'b01); add(1, 2'b01, 2'b01);                         // grant one clk after req
        add(1, 2'b00, 2'b00); add(1, 2'b00, 2'b00); add(1, 2'b00, 2'b00);   // gap, gap, idle
        add(0, 2'b00, 2'b00);
        add(1, 2'b11, 2'b01); add(1, 2'b11, 2'b01);                         // simultaneous: m0 first after reset
        add(1, 2'b10, 2'b00); add(1, 2'b10, 2'b00); add(1, 2'b10, 2'b00);   // two gap cycles, idle samples
        add(1, 2'b10, 2'b10);
        add(1, 2'b11, 2'b10);                                               // m0 cannot preempt
        add(1, 2'b01, 2'b00);                                               // m1 releases for one cycle
        add(1, 2'b11, 2'b00); add(1, 2'b11, 2'b00);
        add(1, 2'b11, 2'b01); add(1, 2'b11, 2'b01);                         // round-robin hands it to m0
        add(0, 2'b11, 2'b00);                                               // reset mid-ownership
        add(1, 2'b11, 2'b01);                                               // no gap after reset

        foreach (tbl[i]) begin
            rst_in_n = tbl[i].rst_n;
            req      = tbl[i].req;
            tick();
            chk_bus($sformatf("vec%0d", i), (tbl[i].gnt == 2'b01) ? 0 : (tbl[i].gnt == 2'b10) ? 1 : -1);
            chk($sformatf("vec%0d.timeout", i), 16'(timeout), 16'd0);
        end

        // Reset pulse while master 1 owns with a chip select asserted.
        rst_in_n = 1'b0; req = 2'b00; tick();
        rst_in_n = 1'b1; req = 2'b10; m1_ncs = 2'b10; tick();
        chk("own1.gnt", 16'(gnt), 16'h2);
        chk("own1.spi_ncs", 16'(spi_ncs), 16'h2);
        chk("own1.m0_miso", 16'(m0_miso), 16'h1);
        rst_in_n = 1'b0; tick();
        chk("rst_own1.gnt", 16'(gnt), 16'h0);
        chk("rst_own1.spi_ncs", 16'(spi_ncs), 16'h3);
        rst_in_n = 1'b1; tick();
        chk("rst_own1.regrant", 16'(gnt), 16'h2);

        // Long ownership of master 0: revoked after TIMEOUT cycles only when the timeout is built in.
        rst_in_n = 1'b0; req = 2'b00; tick();
        rst_in_n = 1'b1; req = 2'b01; tick();
        chk("long.k0.gnt", 16'(gnt), 16'h1);
`ifdef SPI_ARB_TIMEOUT_EN
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            chk($sformatf("to.k%0d.gnt", k), 16'(gnt), 16'h1);
            chk($sformatf("to.k%0d.timeout", k), 16'(timeout), 16'h0);
        end
        tick();
        chk("to.revoke.gnt", 16'(gnt), 16'h0);
        chk("to.revoke.timeout", 16'(timeout), 16'h1);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk($sformatf("to.masked%0d.gnt", k), 16'(gnt), 16'h0);
            chk($sformatf("to.masked%0d.timeout", k), 16'(timeout), 16'h0);
        end
        req = 2'b00; tick();
        chk("to.release.gnt", 16'(gnt), 16'h0);
        req = 2'b01; tick();
        chk("to.regrant.gnt", 16'(gnt), 16'h1);
`else
        for (int k = 1; k < 40; k++) begin
            tick();
            chk($sformatf("long.k%0d.gnt", k), 16'(gnt), 16'h1);
            chk($sformatf("long.k%0d.timeout", k), 16'(timeout), 16'h0);
        end
`endif

        // Random traffic against the reference model, plus the bus-level invariants.
        rst_in_n = 1'b0; req = 2'b00; tick();
        for (int c = 0; c < 20000; c++) begin
            rst_in_n = ($urandom_range(399) != 0);
            if ($urandom_range(5) == 0) req[0] = ~req[0];
            if ($urandom_range(5) == 0) req[1] = ~req[1];
            {m0_sclk, m0_mosi, m0_ncs, m1_sclk, m1_mosi, m1_ncs, spi_miso} = 9'($urandom);
            tick();
            chk_bus("rand", mo_owner);
            chk("rand.timeout", 16'(timeout), 16'(mo_to));
            chk("rand.gnt_not_both", 16'(gnt == 2'b11), 16'h0);
            chk("rand.idle_ncs", 16'((gnt == 2'b00) && (spi_ncs != 2'b11)), 16'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
